pico_stream_out_arb: RTL and testbench
======================================

# pico_stream_out_arb

Round-robin arbiter that shares one PicoStreamOut input port (128-bit valid/ready stream toward the host) among NUM_SRC result producers in the PicoClk domain. It grants one source at a time for a burst that ends on the source's last flag or on a MAX_BURST beat limit, then rotates priority. It sits between the Smith-Waterman engine result ports and the PicoStreamOut s_valid/s_data/s_rdy inputs.

## Interface
- NUM_SRC, 4: number of requesters, 2..16.
- MAX_BURST, 16: maximum data beats per grant, 1..256.
- PicoClk  input  1  clock; all logic is in this domain.
- rst  input  1  reset, synchronous, active-high.
- src_valid  input  NUM_SRC  per-source beat valid.
- src_data  input  NUM_SRC*128  per-source beat data; source i occupies [128*i+127:128*i].
- src_last  input  NUM_SRC  per-source end-of-packet flag, qualified by src_valid.
- src_rdy  output  NUM_SRC  per-source ready; a beat transfers when src_valid[i] && src_rdy[i].
- out_valid  output  1  to PicoStreamOut s_valid.
- out_data  output  128  to PicoStreamOut s_data.
- out_rdy  input  1  from PicoStreamOut s_rdy.
- grant_id  output  4  index of the current or most recent grant.
- beat_cnt  output  32  total beats accepted at the output, headers included.

## Operation
- States: IDLE, HDR (only with ARB_HDR_EN), BURST.
- IDLE: if any src_valid is high, pick the first valid index searching from (rr_ptr+1) mod NUM_SRC upward with wrap. On the next edge, load grant_id and rr_ptr with that index and clear the burst counter. Go to HDR if ARB_HDR_EN is defined, else BURST. If no src_valid is high, stay in IDLE.
- BURST, combinational datapath:
  - out_valid = src_valid[grant_id]
  - out_data = src_data[grant_id]
  - src_rdy[grant_id] = out_rdy; all other src_rdy are 0.
- Transfer: out_valid && out_rdy. Each transfer increments the burst counter (9-bit) and beat_cnt (wraps at 2^32).
- Release: a transfer with src_last[grant_id] = 1, or the transfer that makes the burst counter equal MAX_BURST. Either one returns the block to IDLE on the next edge. A forced release does not drop the source's remaining data; the source is rearbitrated later.
- The grant is held while the granted source deasserts valid mid-burst. There is no timeout.
- While out_rdy is low, the grant is held and no source sees ready.
- In IDLE and HDR, all src_rdy are 0.
- Outside BURST and HDR, out_valid = 0 and out_data = 0.

## Timing
- Reset values:
  - state IDLE, grant_id 0, rr_ptr NUM_SRC-1 (so source 0 has first priority), beat_cnt 0, header sequence 0.
  - out_valid 0, src_rdy all 0, out_data 0.
- Arbitration latency: one PicoClk cycle from src_valid rising in IDLE to the first possible output beat, or to the header beat with ARB_HDR_EN.
- Inter-grant bubble: exactly one IDLE cycle after every release.
- Peak throughput: MAX_BURST/(MAX_BURST+1) beats per cycle, or MAX_BURST/(MAX_BURST+2) with headers.
- Source data reaches the output with zero latency in BURST. src_rdy depends combinationally on out_rdy, which PicoStreamOut registers.
- Reset mid-burst: the block returns to IDLE on that edge and no transfer is counted in that cycle.

## Configuration
- ARB_HDR_EN defined:
  - HDR state drives out_valid = 1 and out_data = {104'h0, hdr_seq[7:0], 12'h0, grant_id[3:0]}.
  - It moves to BURST on out_rdy. hdr_seq increments (wraps at 256) on each accepted header.
  - Headers count in beat_cnt but not in the burst counter.
- ARB_HDR_EN undefined: the HDR state and hdr_seq are absent, IDLE goes directly to BURST, and the output carries only source beats.

## Test plan
- Single source: src 2 sends 3 beats with last on beat 3, out_rdy=1. Expect the first beat 1 cycle after valid, 3 output beats in order, grant_id=2, beat_cnt=3, then IDLE.
- Round-robin: all 4 sources continuously valid, 1-beat packets. Expect grant order 0,1,2,3,0,1 with 1 idle cycle between grants.
- Burst cap: MAX_BURST=4, src 1 sends a 10-beat packet alone. Expect grants of 4,4,2 beats with a bubble between each; data stays in order and last passes on beat 10.
- Backpressure: out_rdy low for 5 cycles mid-burst. Expect out_data held, src_rdy[grant]=0, no beat_cnt change, and the grant kept.
- Reset mid-burst: rst on beat 2 of 5. Expect out_valid=0 and src_rdy=0 the next cycle, beat_cnt=0, and source 0 with first priority afterwards.
- ARB_HDR_EN: two grants (src 3, then src 0). Expect header beats with low 32 bits 0x00000003 then 0x00010000, each preceding its data beats.

Source files
------------

// File: rtl/pico_stream_out_arb.sv
// -----------------------------------------------------------------------------
// pico_stream_out_arb
//
// Round-robin arbiter that shares a single 128-bit valid/ready stream toward
// PicoStreamOut among NUM_SRC result producers. One source is granted at a
// time for a burst that ends on the source's last flag or after MAX_BURST
// beats. Priority then rotates so the next search starts just after the
// source that was granted.
//
// Optional feature: define ARB_HDR_EN to send one header beat in front of
// every grant. The header carries a rolling 8-bit sequence number and the
// granted source index. Without the macro, only source beats reach the output.
//
// Parameters
//   NUM_SRC    number of requesters (2..16)
//   MAX_BURST  maximum data beats per grant (1..256)
//
// Ports
//   PicoClk    clock; every flop in this block is in this domain
//   rst        synchronous, active-high reset
//   src_valid  per-source beat valid
//   src_data   per-source beat data, source i at [128*i+127 : 128*i]
//   src_last   per-source end-of-packet flag, qualified by src_valid
//   src_rdy    per-source ready; only the granted source sees out_rdy
//   out_valid  stream valid toward PicoStreamOut s_valid
//   out_data   stream data toward PicoStreamOut s_data
//   out_rdy    stream ready from PicoStreamOut s_rdy
//   grant_id   index of the current or most recent grant
//   beat_cnt   total beats accepted at the output (headers included)
// -----------------------------------------------------------------------------
module pico_stream_out_arb #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     PicoClk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*128-1:0]   src_data,
    input  logic [NUM_SRC-1:0]       src_last,
    output logic [NUM_SRC-1:0]       src_rdy,
    output logic                     out_valid,
    output logic [127:0]             out_data,
    input  logic                     out_rdy,
    output logic [3:0]               grant_id,
    output logic [31:0]              beat_cnt
);

    // Source vectors are padded to 16 entries so a 4-bit grant index can
    // address them directly for any NUM_SRC without going out of range.
    localparam int MAX_SRC = 16;

`ifdef ARB_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BURST = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd2
    } state_t;
`endif

    state_t         r_state;
    state_t         w_state_next;

    logic [3:0]     r_grant_id;
    logic [3:0]     r_rr_ptr;
    logic [8:0]     r_burst_cnt;
    logic [31:0]    r_beat_cnt;
`ifdef ARB_HDR_EN
    logic [7:0]     r_hdr_seq;
`endif

    logic [MAX_SRC-1:0] w_valid_pad;
    logic [MAX_SRC-1:0] w_last_pad;
    logic [127:0]       w_data_pad [MAX_SRC];

    logic [3:0]     w_cand_idx [NUM_SRC];
    logic           w_pick_any;
    logic [3:0]     w_pick_idx;

    logic           w_in_burst;
    logic           w_burst_full;
    logic           w_xfer;
    logic           w_hdr_xfer;

    genvar gi;

    // -------------------------------------------------------------------------
    // Unpack the flat source buses into 16-entry arrays; unused slots read 0.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < MAX_SRC; gi++) begin : g_pad
            if (gi < NUM_SRC) begin : g_real
                assign w_valid_pad[gi] = src_valid[gi];
                assign w_last_pad[gi]  = src_last[gi];
                assign w_data_pad[gi]  = src_data[gi*128 +: 128];
            end else begin : g_unused
                assign w_valid_pad[gi] = 1'b0;
                assign w_last_pad[gi]  = 1'b0;
                assign w_data_pad[gi]  = '0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin search order: candidate k is (rr_ptr + 1 + k) mod NUM_SRC.
    // rr_ptr is always below NUM_SRC, so the sum stays below 2*NUM_SRC and a
    // single conditional subtract gives the modulo.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            logic [5:0] w_sum;
            assign w_sum          = 6'(r_rr_ptr) + 6'(gi + 1);
            assign w_cand_idx[gi] = (w_sum >= 6'(NUM_SRC)) ? 4'(w_sum - 6'(NUM_SRC))
                                                           : 4'(w_sum);
        end
    endgenerate

    // Walk candidates from the back so the lowest-numbered valid one wins.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_valid_pad[w_cand_idx[k]]) begin
                w_pick_any = 1'b1;
                w_pick_idx = w_cand_idx[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Ready fan-out: only the granted source sees out_rdy, and only in BURST.
    // -------------------------------------------------------------------------
    assign w_in_burst = (r_state == ST_BURST);

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_rdy
            assign src_rdy[gi] = w_in_burst && out_rdy && (r_grant_id == 4'(gi));
        end
    endgenerate

    // The transfer being accepted now is the one that reaches MAX_BURST.
    assign w_burst_full = ((r_burst_cnt + 9'd1) == 9'(MAX_BURST));

    // -------------------------------------------------------------------------
    // Next-state and output datapath
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        out_data     = '0;
        w_xfer       = 1'b0;
        w_hdr_xfer   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
`ifdef ARB_HDR_EN
                    w_state_next = ST_HDR;
`else
                    w_state_next = ST_BURST;
`endif
                end
            end

`ifdef ARB_HDR_EN
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = {104'h0, r_hdr_seq, 12'h0, r_grant_id};
                if (out_rdy) begin
                    w_hdr_xfer   = 1'b1;
                    w_state_next = ST_BURST;
                end
            end
`endif

            ST_BURST: begin
                // Zero-latency pass-through of the granted source. The grant
                // is held even while that source drops valid.
                out_valid = w_valid_pad[r_grant_id];
                out_data  = w_data_pad[r_grant_id];
                w_xfer    = w_valid_pad[r_grant_id] && out_rdy;
                if (w_xfer && (w_last_pad[r_grant_id] || w_burst_full)) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge PicoClk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Grant bookkeeping and counters. rr_ptr resets to the last source so the
    // first search after reset starts at source 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge PicoClk) begin
        if (rst) begin
            r_grant_id  <= '0;
            r_rr_ptr    <= 4'(NUM_SRC - 1);
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_pick_any) begin
                r_grant_id  <= w_pick_idx;
                r_rr_ptr    <= w_pick_idx;
                r_burst_cnt <= '0;
            end else if (w_xfer) begin
                r_burst_cnt <= r_burst_cnt + 9'd1;
            end

            // Headers count toward the total but not toward the burst limit.
            if (w_xfer || w_hdr_xfer) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

`ifdef ARB_HDR_EN
    always_ff @(posedge PicoClk) begin
        if (rst) begin
            r_hdr_seq <= '0;
        end else if (w_hdr_xfer) begin
            r_hdr_seq <= r_hdr_seq + 8'd1;
        end
    end
`endif

    assign grant_id = r_grant_id;
    assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_pico_stream_out_arb.sv
`timescale 1ns/1ps
module tb_pico_stream_out_arb;

    localparam int NUM_SRC   = 4;
    localparam int MAX_BURST = 4;
`ifdef ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic                   PicoClk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_SRC-1:0]     src_valid = '0;
    logic [NUM_SRC*128-1:0] src_data = '0;
    logic [NUM_SRC-1:0]     src_last = '0;
    logic [NUM_SRC-1:0]     src_rdy;
    logic                   out_valid;
    logic [127:0]           out_data;
    logic                   out_rdy = 1'b1;
    logic [3:0]             grant_id;
    logic [31:0]            beat_cnt;

    pico_stream_out_arb #(
        .NUM_SRC   (NUM_SRC),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .PicoClk   (PicoClk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_rdy   (src_rdy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .grant_id  (grant_id),
        .beat_cnt  (beat_cnt)
    );

    always #5 PicoClk = ~PicoClk;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } src_beat_t;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   gid;
        logic         is_hdr;
        int           gap;     // required cycles since previous output beat, 0 = don't care
    } exp_t;

    src_beat_t   src_q [NUM_SRC][$];
    exp_t        exp_q[$];
    int          xfer_cyc[$];
    logic [31:0] hdr_low[$];

    int          cyc = 0;
    int          last_xfer = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_beats = 0;
    logic [7:0]  exp_seq = '0;

    function automatic logic [127:0] mk_data(int src, int n);
        logic [31:0] mix;
        mix = 32'(n) * 32'h9E37_79B9;
        return {4'hA, 4'(src), 24'(n), mix, 64'h0123_4567_89AB_CDEF ^ 64'(src * 256 + n)};
    endfunction

    function automatic bit src_pending();
        for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(int src, int n, bit last);
        src_beat_t b;
        b.data = mk_data(src, n);
        b.last = last;
        src_q[src].push_back(b);
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                src_valid[i]            = 1'b1;
                src_data[i*128 +: 128]  = src_q[i][0].data;
                src_last[i]             = src_q[i][0].last;
            end else begin
                src_valid[i]            = 1'b0;
                src_data[i*128 +: 128]  = '0;
                src_last[i]             = 1'b0;
            end
        end
    endtask

    // Expected output of one grant: optional header, then cnt data beats.
    task automatic expect_grant(int src, int first_n, int cnt, int first_gap, int inner_gap);
        exp_t e;
        int   g;
        g = first_gap;
`ifdef ARB_HDR_EN
        e.data   = {104'h0, exp_seq, 12'h0, 4'(src)};
        e.gid    = 4'(src);
        e.is_hdr = 1'b1;
        e.gap    = g;
        exp_q.push_back(e);
        exp_seq++;
        exp_beats++;
        g = inner_gap;
`endif
        for (int k = 0; k < cnt; k++) begin
            e.data   = mk_data(src, first_n + k);
            e.gid    = 4'(src);
            e.is_hdr = 1'b0;
            e.gap    = g;
            exp_q.push_back(e);
            exp_beats++;
            g = inner_gap;
        end
    endtask

    // One clock: sample at the falling edge, update sources after the rising edge.
    task automatic step();
        logic [NUM_SRC-1:0] hs;
        exp_t e;
        @(negedge PicoClk);
        cyc++;
        hs = src_valid & src_rdy;
        checks++;
        if ($countones(src_rdy) > 1) begin
            errors++;
            $display("FAIL rdy_onehot cyc=%0d src_rdy=%b required at most one bit", cyc, src_rdy);
        end
        if (out_valid && out_rdy) begin
            xfer_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat cyc=%0d gid=%0d data=%h required no beat", cyc, grant_id, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || grant_id !== e.gid) begin
                    errors++;
                    $display("FAIL beat cyc=%0d got gid=%0d data=%h required gid=%0d data=%h",
                             cyc, grant_id, out_data, e.gid, e.data);
                end else begin
                    $display("beat cyc=%0d gid=%0d hdr=%0d data=%h", cyc, grant_id, e.is_hdr, out_data);
                end
                if (e.is_hdr) hdr_low.push_back(out_data[31:0]);
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_xfer != e.gap) begin
                        errors++;
                        $display("FAIL beat_gap cyc=%0d got %0d cycles required %0d", cyc, cyc - last_xfer, e.gap);
                    end
                end
            end
            last_xfer = cyc;
        end
        @(posedge PicoClk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) src_q[i].pop_front();
        end
        drive_srcs();
    endtask

    task automatic clear_sb();
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        exp_q.delete();
        xfer_cyc.delete();
        hdr_low.delete();
        exp_beats = 0;
        exp_seq   = '0;
        drive_srcs();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        out_rdy = 1'b1;
        clear_sb();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(int budget, string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || src_pending()) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() > 0 || src_pending()) begin
            errors++;
            $display("FAIL %s_timeout got %0d beats outstanding required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_xfers(int cnt, int budget, string name);
        int n;
        n = 0;
        while (xfer_cyc.size() < cnt && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (xfer_cyc.size() < cnt) begin
            errors++;
            $display("FAIL %s_wait got %0d beats required %0d", name, xfer_cyc.size(), cnt);
        end
    endtask

    task automatic check_idle(string name, logic [3:0] gid, int cnt);
        checks++;
        if (out_valid !== 1'b0 || src_rdy !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL %s_idle got out_valid=%b src_rdy=%b required 0/0", name, out_valid, src_rdy);
        end
        checks++;
        if (grant_id !== gid) begin
            errors++;
            $display("FAIL %s_grant got %0d required %0d", name, grant_id, gid);
        end
        checks++;
        if (beat_cnt !== 32'(cnt)) begin
            errors++;
            $display("FAIL %s_beat_cnt got %0d required %0d", name, beat_cnt, cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle("reset", 4'd0, 0);
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        load(2, 0, 1'b0);
        load(2, 1, 1'b0);
        load(2, 2, 1'b1);
        drive_srcs();
        t0 = cyc;
        expect_grant(2, 0, 3, 0, 1);
        drain(50, "single");
        checks++;
        if (xfer_cyc.size() != 3 + HDR) begin
            errors++;
            $display("FAIL single_count got %0d beats required %0d", xfer_cyc.size(), 3 + HDR);
        end else begin
            checks++;
            if (xfer_cyc[0] != t0 + 2) begin
                errors++;
                $display("FAIL single_latency got cycle %0d required %0d", xfer_cyc[0], t0 + 2);
            end
        end
        check_idle("single", 4'd2, 3 + HDR);
    endtask

    task automatic test_round_robin();
        do_reset();
        load(0, 0, 1'b1); load(0, 1, 1'b1);
        load(1, 0, 1'b1); load(1, 1, 1'b1);
        load(2, 0, 1'b1);
        load(3, 0, 1'b1);
        drive_srcs();
        expect_grant(0, 0, 1, 0, 1);
        expect_grant(1, 0, 1, 2, 1);
        expect_grant(2, 0, 1, 2, 1);
        expect_grant(3, 0, 1, 2, 1);
        expect_grant(0, 1, 1, 2, 1);
        expect_grant(1, 1, 1, 2, 1);
        drain(100, "rr");
        check_idle("rr", 4'd1, 6 * (1 + HDR));
    endtask

    task automatic test_burst_cap();
        do_reset();
        for (int n = 0; n < 10; n++) load(1, n, n == 9);
        drive_srcs();
        expect_grant(1, 0, 4, 0, 1);
        expect_grant(1, 4, 4, 2, 1);
        expect_grant(1, 8, 2, 2, 1);
        drain(100, "cap");
        checks++;
        if (xfer_cyc.size() != 10 + 3 * HDR) begin
            errors++;
            $display("FAIL cap_count got %0d beats required %0d", xfer_cyc.size(), 10 + 3 * HDR);
        end
        check_idle("cap", 4'd1, 10 + 3 * HDR);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int n = 0; n < 4; n++) load(0, n, n == 3);
        drive_srcs();
        expect_grant(0, 0, 4, 0, 0);
        wait_xfers(2, 20, "bp");
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0 || out_data !== exp_q[0].data) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got valid=%b data=%h", cyc, out_valid, out_data);
            end
            checks++;
            if (src_rdy !== '0) begin
                errors++;
                $display("FAIL bp_rdy cyc=%0d got src_rdy=%b required 0", cyc, src_rdy);
            end
            checks++;
            if (beat_cnt !== 32'd2 || grant_id !== 4'd0) begin
                errors++;
                $display("FAIL bp_state cyc=%0d got beat_cnt=%0d gid=%0d required 2/0", cyc, beat_cnt, grant_id);
            end
        end
        out_rdy = 1'b1;
        drain(50, "bp");
        check_idle("bp", 4'd0, 4 + HDR);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 5; n++) load(0, n, n == 4);
        drive_srcs();
        expect_grant(0, 0, 2, 0, 1);
        wait_xfers(1 + HDR, 20, "rstmid");
        rst = 1'b1;
        step();
        check_idle("rstmid", 4'd0, 0);
        rst = 1'b0;
        clear_sb();
        load(0, 10, 1'b1);
        load(1, 10, 1'b1);
        drive_srcs();
        expect_grant(0, 10, 1, 0, 1);
        expect_grant(1, 10, 1, 2, 1);
        drain(50, "rstmid_after");
        check_idle("rstmid_after", 4'd1, 2 * (1 + HDR));
    endtask

`ifdef ARB_HDR_EN
    task automatic test_hdr();
        do_reset();
        load(3, 0, 1'b0);
        load(3, 1, 1'b1);
        drive_srcs();
        expect_grant(3, 0, 2, 0, 1);
        wait_xfers(1, 20, "hdr");
        load(0, 0, 1'b1);
        drive_srcs();
        expect_grant(0, 0, 1, 2, 1);
        drain(50, "hdr");
        checks++;
        if (hdr_low.size() != 2) begin
            errors++;
            $display("FAIL hdr_count got %0d headers required 2", hdr_low.size());
        end else begin
            checks++;
            if (hdr_low[0] !== 32'h0000_0003 || hdr_low[1] !== 32'h0001_0000) begin
                errors++;
                $display("FAIL hdr_words got %h %h required 00000003 00010000", hdr_low[0], hdr_low[1]);
            end
        end
        check_idle("hdr", 4'd0, 5);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_reset_mid();
`ifdef ARB_HDR_EN
        test_hdr();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
